// File: rtl/frac_cen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
package frac_cen_pkg;

  localparam int PHASE_W = 32;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t INC_HALF    = 32'h8000_0000;
  localparam phase_t INC_QUARTER = 32'h4000_0000;

  // Increment giving an average enable rate of num/den of refclk.
  // Intended for elaboration-time constants only (uses a 64-bit divide).
  function automatic phase_t inc_from_ratio(input int unsigned num, input int unsigned den);
    logic [63:0] scaled;
    scaled = {32'd0, num} << PHASE_W;
    return phase_t'(scaled / {32'd0, den});
  endfunction

endpackage

// File: rtl/frac_cen_chan.sv
// One channel of the fractional enable generator: phase accumulator,
// active and shadow increments, and the glitch-free commit of new rates.
module frac_cen_chan
  import frac_cen_pkg::*;
#(
  parameter int            ACC_W    = 32,
  parameter logic [ACC_W-1:0] INIT_INC = INC_HALF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync,
  input  logic             we,
  input  logic [ACC_W-1:0] inc,
  output logic             pend,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_act;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;
  logic             add_carry;
  logic             commit;

  // Next phase and commit decision; a new rate is taken only at a wrap, when idle, or on sync.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, inc_act};
    add_carry = run && !sync && sum[ACC_W];
    commit    = pend && (sync || add_carry || (inc_act == '0) || !run);
  end

  // Accumulator, registered carry and increment shadow/commit registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      inc_act <= INIT_INC;
      shadow  <= INIT_INC;
      pend    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      if (sync) begin
        acc <= '0;
      end else if (run) begin
        acc <= sum[ACC_W-1:0];
      end
      carry <= add_carry;
      if (commit) begin
        inc_act <= shadow;
        pend    <= 1'b0;
      end
      if (we) begin
        shadow <= inc;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator with a PLL-style lock flag.
module frac_cen_gen
  import frac_cen_pkg::*;
#(
  parameter int               CHANNELS    = 2,
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] INIT_INC    = INC_HALF,
  parameter int               LOCK_CYCLES = 1024
) (
  input  logic                                          refclk,
  input  logic                                          rst,
  input  logic                                          run,
  input  logic                                          sync,
  input  logic                                          cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                              cfg_inc,
  output logic [CHANNELS-1:0]                           cfg_pend,
  output logic [CHANNELS-1:0]                           cen,
  output logic                                          locked
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_CYCLES);

  logic [CHANNELS-1:0] ch_we;
  logic [CHANNELS-1:0] carry;
  logic [LC_W-1:0]     lock_cnt;
  logic                clean;

  // Route a config write to its channel; out-of-range indices select nothing.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        ch_we[i] = 1'b1;
      end
    end
    clean = run && !sync && !cfg_we && (cfg_pend == '0);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    frac_cen_chan #(
      .ACC_W    (ACC_W),
      .INIT_INC (INIT_INC)
    ) u_chan (
      .refclk (refclk),
      .rst    (rst),
      .run    (run),
      .sync   (sync),
      .we     (ch_we[i]),
      .inc    (cfg_inc),
      .pend   (cfg_pend[i]),
      .carry  (carry[i])
    );
  end

  // Enable outputs: one refclk wide, suppressed while stopped or aligning.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cen <= '0;
    end else if (run && !sync) begin
      cen <= carry;
    end else begin
      cen <= '0;
    end
  end

  // Lock tracking: count clean running cycles, drop a cycle after any disturbance.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (sync) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (clean) begin
        if (lock_cnt != LOCK_MAX) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else begin
        lock_cnt <= '0;
      end
      locked <= (lock_cnt == LOCK_MAX);
    end
  end

endmodule
